// File: rtl/ram_access_ctrl.sv
// Request-side controller for an 8-bit, 256-entry RAM with one-cycle read latency.
// Accepts 1..16 beat read/write bursts, rejects anything outside the BASE[15:8] window.
module ram_access_ctrl #(
    parameter logic [15:0] BASE = 16'h8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [3:0]  req_len,
    input  logic [7:0]  wdata,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    input  logic        rdata_ready,
    output logic        done,
    output logic        err,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WR_BEAT,
        RD_ISSUE,
        RD_CAPTURE,
        RD_HOLD,
        DONE
    } state_t;

    state_t      state_q;
    logic [15:0] ptr_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic        req_ready_q;
    logic        done_q;
    logic        err_q;
    logic        rdata_valid_q;
    logic [7:0]  rdata_q;

    logic [7:0]  ptr_lo_d;
    logic [8:0]  end_sum;
    logic        err_int;
    logic        wr_phase;
    logic        rd_phase;

    // 9-bit sum so a burst ending past 0xFF is caught rather than wrapping
    assign end_sum  = {1'b0, ptr_q[7:0]} + {5'b0_0000, cnt_q};
    assign err_int  = (ptr_q[15:8] != BASE[15:8]) || (end_sum > 9'd255);
    assign ptr_lo_d = ptr_q[7:0] + 8'd1;

    // RAM-facing strobes are gated by rst_n so nothing reaches the RAM in a reset cycle
    assign wr_phase    = rst_n && (state_q == WR_BEAT);
    assign rd_phase    = rst_n && (state_q == RD_ISSUE);
    assign wdata_ready = wr_phase;
    assign ram_we      = wr_phase && wdata_valid;
    assign ram_wdata   = wr_phase ? wdata : 8'h00;
    assign ram_addr    = (wr_phase || rd_phase) ? ptr_q : 16'h0000;

    assign req_ready   = req_ready_q;
    assign done        = done_q;
    assign err         = err_q;
    assign rdata_valid = rdata_valid_q;
    assign rdata       = rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        ptr_q       <= req_addr;
                        cnt_q       <= req_len;
                        write_q     <= req_write;
                        req_ready_q <= 1'b0;
                        state_q     <= CHECK;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                CHECK: begin
                    if (err_int) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (write_q) begin
                        state_q <= WR_BEAT;
                    end else begin
                        state_q <= RD_ISSUE;
                    end
                end
                WR_BEAT: begin
                    if (wdata_valid) begin
                        ptr_q[7:0] <= ptr_lo_d;
                        if (cnt_q == 4'd0) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                RD_ISSUE: begin
                    state_q <= RD_CAPTURE;
                end
                RD_CAPTURE: begin
                    rdata_q       <= ram_rdata;
                    rdata_valid_q <= 1'b1;
                    state_q       <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (rdata_ready) begin
                        rdata_valid_q <= 1'b0;
                        if (cnt_q == 4'd0) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            cnt_q      <= cnt_q - 4'd1;
                            ptr_q[7:0] <= ptr_lo_d;
                            state_q    <= RD_ISSUE;
                        end
                    end
                end
                DONE: begin
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    req_ready_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule
